// File: rtl/map_painter_pkg.sv
// map_painter_pkg
//   Shared definitions for the background tile map write engine and for the
//   display-side reader: map geometry, address packing and FSM states.
//   Contents:
//     COL_W, ROW_W, COLOR_W  tile column / row index widths and colour width
//     ADDR_W                 tile RAM address width ({row, col})
//     MAP_COLS, MAP_ROWS     map size in tiles
//     state_t                fill engine states
//     tile_addr()            packs a row/column pair into a RAM address
package map_painter_pkg;

  localparam int COL_W    = 7;
  localparam int ROW_W    = 9;
  localparam int COLOR_W  = 12;
  localparam int ADDR_W   = ROW_W + COL_W;
  localparam int MAP_COLS = 128;
  localparam int MAP_ROWS = 512;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // The display path reads with exactly this packing, so both sides must
  // go through this function rather than building the address by hand.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/map_painter_if.sv
// map_painter_if
//   Fill-rectangle command channel (valid/ready) between scene logic and the
//   map painter.
//   Signals:
//     cmd_valid  producer -> engine  command present
//     cmd_ready  engine -> producer  engine is idle and will take a command
//     cmd_x0     producer -> engine  left tile column
//     cmd_y0     producer -> engine  top tile row
//     cmd_w      producer -> engine  width in tiles, 0..MAP_COLS
//     cmd_h      producer -> engine  height in tiles, 0..MAP_ROWS
//     cmd_color  producer -> engine  RGB444 fill colour
//   Modports: master (command producer), slave (map painter).
interface map_painter_if;
  import map_painter_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [COL_W-1:0]   cmd_x0;
  logic [ROW_W-1:0]   cmd_y0;
  logic [COL_W:0]     cmd_w;
  logic [ROW_W:0]     cmd_h;
  logic [COLOR_W-1:0] cmd_color;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/map_painter.sv
// map_painter
//   Write-side engine for the background tile RAM. Takes fill-rectangle
//   commands and writes the colour into every covered tile, one tile per
//   clock, row-major, clipped to the map edges.
//   Ports:
//     clock        system clock, rising edge
//     resetn       synchronous active-low reset
//     cmd          command channel (map_painter_if.slave)
//     busy         a fill is in progress
//     done         one-cycle pulse when a command has completed
//     mem_address  tile RAM write address {row, col}
//     mem_data     tile RAM write data (fill colour)
//     mem_wren     tile RAM write enable
module map_painter
  import map_painter_pkg::*;
(
  input  logic               clock,
  input  logic               resetn,
  map_painter_if.slave       cmd,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wren
);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   x0_q, x0_d;
  logic [COL_W-1:0]   last_col_q, last_col_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [COLOR_W-1:0] data_d;
  logic               wren_d;
  logic               done_d;

  logic [COL_W:0]     avail_w, eff_w;
  logic [ROW_W:0]     avail_h, eff_h;
  logic [COL_W-1:0]   clip_last_col;
  logic [ROW_W-1:0]   clip_last_row;

  assign cmd.cmd_ready = (state_q == IDLE);
  assign busy          = (state_q == FILL);

  // Clip the incoming rectangle against the map edge. The room left to the
  // edge is always 1..MAP_COLS (1..MAP_ROWS), so the extra bit never wraps.
  // The last column/row is then computed modulo the index width: the true
  // value always lies inside the map, so dropping the top bit of the width
  // (e.g. a full 128-wide fill) still lands on the right index.
  always_comb begin
    avail_w       = (COL_W+1)'(MAP_COLS) - {1'b0, cmd.cmd_x0};
    avail_h       = (ROW_W+1)'(MAP_ROWS) - {1'b0, cmd.cmd_y0};
    eff_w         = (cmd.cmd_w < avail_w) ? cmd.cmd_w : avail_w;
    eff_h         = (cmd.cmd_h < avail_h) ? cmd.cmd_h : avail_h;
    clip_last_col = cmd.cmd_x0 + eff_w[COL_W-1:0] - COL_W'(1);
    clip_last_row = cmd.cmd_y0 + eff_h[ROW_W-1:0] - ROW_W'(1);
  end

  // Next-state and next-output logic. Each cycle in FILL shows one write on
  // the registered outputs; col_q/row_q track the tile currently presented,
  // so once it equals the last tile the next cycle becomes the done cycle.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    x0_d       = x0_q;
    last_col_d = last_col_q;
    last_row_d = last_row_q;
    addr_d     = mem_address;
    data_d     = mem_data;
    wren_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          if ((eff_w == '0) || (eff_h == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d    = FILL;
            x0_d       = cmd.cmd_x0;
            col_d      = cmd.cmd_x0;
            row_d      = cmd.cmd_y0;
            last_col_d = clip_last_col;
            last_row_d = clip_last_row;
            addr_d     = tile_addr(cmd.cmd_y0, cmd.cmd_x0);
            data_d     = cmd.cmd_color;
            wren_d     = 1'b1;
          end
        end
      end

      FILL: begin
        if ((col_q == last_col_q) && (row_q == last_row_q)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wren_d = 1'b1;
          if (col_q == last_col_q) begin
            col_d = x0_q;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          addr_d = tile_addr(row_d, col_d);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, scan counters and all outputs are registered here; reset drops
  // any fill in progress without a done pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      x0_q        <= '0;
      last_col_q  <= '0;
      last_row_q  <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      x0_q        <= x0_d;
      last_col_q  <= last_col_d;
      last_row_q  <= last_row_d;
      mem_address <= addr_d;
      mem_data    <= data_d;
      mem_wren    <= wren_d;
      done        <= done_d;
    end
  end

endmodule

// File: tb/tb_map_painter.sv
// tb_map_painter
//   Self-checking bench for map_painter. Commands are issued through the
//   interface; each issue pushes the expected writes (address, data, cycle)
//   and the expected done cycle into queues, and a monitor on the falling
//   edge pops and compares whatever the engine presents. A model RAM is
//   compared with the RAM image rebuilt from observed writes at the end.
module tb_map_painter;
  import map_painter_pkg::*;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  logic               clock = 1'b0;
  logic               resetn;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  mem_address;
  logic [COLOR_W-1:0] mem_data;
  logic               mem_wren;

  map_painter_if cmd_bus ();

  map_painter dut (
    .clock       (clock),
    .resetn      (resetn),
    .cmd         (cmd_bus),
    .busy        (busy),
    .done        (done),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  wr_t exp_wr[$];
  int  exp_done[$];

  logic [COLOR_W-1:0] model_ram [0:65535];
  logic [COLOR_W-1:0] dut_ram   [0:65535];

  // Cycle numbering: cyc is the count of rising edges so far; a command
  // accepted on the edge that makes cyc == A shows its first write at A.
  always @(posedge clock) cyc++;

  // Monitor: pops and compares every write and every done pulse.
  always @(negedge clock) begin
    wr_t w;
    int  d;
    if (mem_wren === 1'b1) begin
      dut_ram[mem_address] = mem_data;
      n_checks++;
      if (exp_wr.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_write: got addr %h data %h at cycle %0d, required no write",
                 mem_address, mem_data, cyc);
      end else begin
        w = exp_wr.pop_front();
        if ((mem_address !== ADDR_W'(w.addr)) || (mem_data !== COLOR_W'(w.data)) || (cyc != w.cyc)) begin
          n_fail++;
          $display("[TB] FAIL write: got addr %h data %h cycle %0d, required addr %h data %h cycle %0d",
                   mem_address, mem_data, cyc, w.addr[15:0], w.data[11:0], w.cyc);
        end
      end
    end
    if (done === 1'b1) begin
      n_checks++;
      if (exp_done.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_done: got done at cycle %0d, required none", cyc);
      end else begin
        d = exp_done.pop_front();
        if (cyc != d) begin
          n_fail++;
          $display("[TB] FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, d);
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // Presents a command and holds it until the handshake edge; returns the
  // cycle number of that edge (or -1 when the engine never became ready).
  task automatic apply_stimulus(input int x0, input int y0, input int w, input int h,
                                input int color, output int acc);
    bit ok;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_x0    = COL_W'(x0);
    cmd_bus.cmd_y0    = ROW_W'(y0);
    cmd_bus.cmd_w     = (COL_W+1)'(w);
    cmd_bus.cmd_h     = (ROW_W+1)'(h);
    cmd_bus.cmd_color = COLOR_W'(color);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clock);
      if (cmd_bus.cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL handshake_timeout: got cmd_ready low for 3000 cycles, required acceptance");
      cmd_bus.cmd_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clock);
      #1;
      acc = cyc;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_x0    = '1;
      cmd_bus.cmd_y0    = '1;
      cmd_bus.cmd_w     = '1;
      cmd_bus.cmd_h     = '1;
      cmd_bus.cmd_color = '1;
    end
  endtask

  // Expected writes from a small clip model: row-major, one per cycle.
  // max_writes >= 0 truncates the list (aborted fills) and omits done.
  task automatic push_model(input int x0, input int y0, input int w, input int h,
                            input int color, input int acc, input int max_writes);
    int ew, eh, n;
    wr_t e;
    ew = (w < MAP_COLS - x0) ? w : MAP_COLS - x0;
    eh = (h < MAP_ROWS - y0) ? h : MAP_ROWS - y0;
    n  = 0;
    for (int r = 0; r < eh; r++) begin
      for (int c = 0; c < ew; c++) begin
        if ((max_writes < 0) || (n < max_writes)) begin
          e.addr = (y0 + r) * MAP_COLS + (x0 + c);
          e.data = color;
          e.cyc  = acc + n;
          exp_wr.push_back(e);
          model_ram[e.addr] = COLOR_W'(color);
        end
        n++;
      end
    end
    if (max_writes < 0) exp_done.push_back(acc + ew * eh);
  endtask

  // Expected writes from a hand-written address list.
  task automatic push_hand(input int n, input int a0, input int a1, input int a2, input int a3,
                           input int color, input int acc);
    int  addrs [4];
    wr_t e;
    addrs = '{a0, a1, a2, a3};
    for (int i = 0; i < n; i++) begin
      e.addr = addrs[i];
      e.data = color;
      e.cyc  = acc + i;
      exp_wr.push_back(e);
      model_ram[addrs[i]] = COLOR_W'(color);
    end
    exp_done.push_back(acc + n);
  endtask

  initial begin
    int acc, acc2, bad;
    for (int a = 0; a < 65536; a++) begin
      model_ram[a] = '0;
      dut_ram[a]   = '0;
    end
    resetn            = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_x0    = '0;
    cmd_bus.cmd_y0    = '0;
    cmd_bus.cmd_w     = '0;
    cmd_bus.cmd_h     = '0;
    cmd_bus.cmd_color = '0;

    // Reset held for three edges.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_output("reset_cmd_ready", int'(cmd_bus.cmd_ready), 1);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_done", int'(done), 0);
    check_output("reset_mem_wren", int'(mem_wren), 0);
    check_output("reset_mem_address", int'(mem_address), 0);
    check_output("reset_mem_data", int'(mem_data), 0);
    resetn = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // Basic 2x2 fill.
    apply_stimulus(2, 3, 2, 2, 12'hF00, acc);
    push_hand(4, 16'h0182, 16'h0183, 16'h0202, 16'h0203, 12'hF00, acc);
    @(negedge clock);
    check_output("busy_during_fill", int'(busy), 1);
    check_output("ready_during_fill", int'(cmd_bus.cmd_ready), 0);

    // Bottom-right corner clip: only two tiles fit.
    apply_stimulus(126, 511, 5, 4, 12'h0A5, acc);
    push_hand(2, 16'hFFFE, 16'hFFFF, 0, 0, 12'h0A5, acc);

    // Zero-width rectangle: done only.
    apply_stimulus(5, 5, 0, 7, 12'h123, acc);
    push_hand(0, 0, 0, 0, 0, 12'h123, acc);

    // Back-to-back: second command held valid through the first fill.
    apply_stimulus(10, 20, 3, 2, 12'hABC, acc);
    push_model(10, 20, 3, 2, 12'hABC, acc, -1);
    apply_stimulus(0, 0, 1, 1, 12'h0F0, acc2);
    push_hand(1, 16'h0000, 0, 0, 0, 12'h0F0, acc2);
    check_output("back_to_back_accept_cycle", acc2, acc + 3 * 2 + 1);

    // Further fills: overlapping clip, full-width row, full-height column,
    // single corner tile, zero height.
    apply_stimulus(120, 500, 20, 20, 12'h123, acc);
    push_model(120, 500, 20, 20, 12'h123, acc, -1);
    apply_stimulus(0, 0, 5, 3, 12'h00F, acc);
    push_model(0, 0, 5, 3, 12'h00F, acc, -1);
    apply_stimulus(0, 100, 128, 1, 12'h456, acc);
    push_model(0, 100, 128, 1, 12'h456, acc, -1);
    apply_stimulus(3, 0, 1, 512, 12'h789, acc);
    push_model(3, 0, 1, 512, 12'h789, acc, -1);
    apply_stimulus(127, 0, 1, 1, 12'h777, acc);
    push_model(127, 0, 1, 1, 12'h777, acc, -1);
    apply_stimulus(64, 256, 128, 0, 12'h321, acc);
    push_model(64, 256, 128, 0, 12'h321, acc, -1);

    // Full-map fill aborted by reset after the tenth write.
    apply_stimulus(0, 0, 128, 512, 12'hFFF, acc);
    push_model(0, 0, 128, 512, 12'hFFF, acc, 10);
    repeat (9) @(posedge clock);
    #2;
    resetn = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_output("abort_mem_wren", int'(mem_wren), 0);
    check_output("abort_cmd_ready", int'(cmd_bus.cmd_ready), 1);
    check_output("abort_busy", int'(busy), 0);
    check_output("abort_done", int'(done), 0);
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (10) @(posedge clock);

    // Drain the scoreboard.
    for (int t = 0; t < 3000; t++) begin
      if ((exp_wr.size() == 0) && (exp_done.size() == 0)) break;
      @(negedge clock);
    end
    @(posedge clock);
    #1;
    check_output("pending_writes", exp_wr.size(), 0);
    check_output("pending_done", exp_done.size(), 0);

    bad = 0;
    for (int a = 0; a < 65536; a++) begin
      if (dut_ram[a] !== model_ram[a]) bad++;
    end
    check_output("ram_contents_diff_tiles", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
